// File: rtl/mm_stream_sequencer.sv
// Serial-to-parallel operand loader and parallel-to-serial result drainer for the
// 3x3-by-3x1 matrix multiplier core. Optional in_last framing check: MM_FRAME_CHECK_EN.
`ifndef FACTOR_WIDTH_DEFAULT
`define FACTOR_WIDTH_DEFAULT 8
`endif
`ifndef PRODUCT_WIDTH_DEFAULT
`define PRODUCT_WIDTH_DEFAULT 18
`endif

// state | meaning
// LOAD  | accept 12 operand beats, counter = beat index
// COMP  | one cycle, operands stable, core products captured at cycle end
// DRAIN | return C_11, C_21, C_31, counter = result index
module mm_stream_sequencer #(
  parameter int NBITS        = `FACTOR_WIDTH_DEFAULT,
  parameter int RESULT_WIDTH = `PRODUCT_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NBITS-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NBITS-1:0]        op_a_11,
  output logic [NBITS-1:0]        op_a_12,
  output logic [NBITS-1:0]        op_a_13,
  output logic [NBITS-1:0]        op_a_21,
  output logic [NBITS-1:0]        op_a_22,
  output logic [NBITS-1:0]        op_a_23,
  output logic [NBITS-1:0]        op_a_31,
  output logic [NBITS-1:0]        op_a_32,
  output logic [NBITS-1:0]        op_a_33,
  output logic [NBITS-1:0]        op_b_11,
  output logic [NBITS-1:0]        op_b_21,
  output logic [NBITS-1:0]        op_b_31,
  input  logic [RESULT_WIDTH-1:0] res_c_11,
  input  logic [RESULT_WIDTH-1:0] res_c_21,
  input  logic [RESULT_WIDTH-1:0] res_c_31,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef MM_FRAME_CHECK_EN
  input  logic                    in_last,
  output logic                    frame_err,
`endif
  output logic                    out_last
);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] COMP  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]              state;
  logic [3:0]              cnt;
  logic [NBITS-1:0]        op_r  [12];
  logic [RESULT_WIDTH-1:0] res_r [3];
  logic                    frame_ok;

  // A beat whose in_last disagrees with its position aborts the frame
  always_comb begin
    frame_ok = 1'b1;
`ifdef MM_FRAME_CHECK_EN
    frame_ok = (in_last == (cnt == 4'd11));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= 4'd0;
      for (int i = 0; i < 12; i++) op_r[i] <= '0;
      for (int i = 0; i < 3; i++) res_r[i] <= '0;
`ifdef MM_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
`ifdef MM_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
      case (state)
        LOAD: begin
          if (in_valid) begin
            op_r[cnt] <= in_data;
            if (!frame_ok) begin
              cnt <= 4'd0;
`ifdef MM_FRAME_CHECK_EN
              frame_err <= 1'b1;
`endif
            end else if (cnt == 4'd11) begin
              cnt   <= 4'd0;
              state <= COMP;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        COMP: begin
          res_r[0] <= res_c_11;
          res_r[1] <= res_c_21;
          res_r[2] <= res_c_31;
          cnt      <= 4'd0;
          state    <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (cnt == 4'd2) begin
              cnt   <= 4'd0;
              state <= LOAD;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: begin
          cnt   <= 4'd0;
          state <= LOAD;
        end
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      case (cnt)
        4'd0:    out_data = res_r[0];
        4'd1:    out_data = res_r[1];
        default: out_data = res_r[2];
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (cnt == 4'd2);

  assign op_a_11 = op_r[0];
  assign op_a_12 = op_r[1];
  assign op_a_13 = op_r[2];
  assign op_a_21 = op_r[3];
  assign op_a_22 = op_r[4];
  assign op_a_23 = op_r[5];
  assign op_a_31 = op_r[6];
  assign op_a_32 = op_r[7];
  assign op_a_33 = op_r[8];
  assign op_b_11 = op_r[9];
  assign op_b_21 = op_r[10];
  assign op_b_31 = op_r[11];

endmodule
